// File: rtl/hazard_ctrl_if.sv
// Bundle between the ID/EX-side decode fields and the hazard controller's
// pipeline-register controls. The master drives the observed fields; the slave (hazard_ctrl) drives the controls.
interface hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       ex_branch_taken;
  logic       ex_mul_start;

  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_bubble;
  logic       exmem_bubble;
  logic       mul_done;
  logic       busy;
  logic [1:0] state;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, ex_mul_start,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble,
           mul_done, busy, state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, ex_mul_start,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble,
           mul_done, busy, state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, taken-branch flush, multi-cycle multiply freeze.
// Optional HAZARD_PERF_EN adds saturating stall_cycles / flush_count counters.
module hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef HAZARD_PERF_EN
  output logic [15:0]  stall_cycles,
  output logic [15:0]  flush_count,
`endif
  hazard_ctrl_if.slave bus
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MUL_WAIT = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic       w_lu;

  assign w_lu = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  always_comb begin
    bus.pc_write     = 1'b1;
    bus.ifid_write   = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.idex_write   = 1'b1;
    bus.idex_bubble  = 1'b0;
    bus.exmem_bubble = 1'b0;
    bus.mul_done     = 1'b0;
    bus.busy         = (r_state != RUN);
    if (!rst_n) begin
      // Keep the pipeline flushed and stationary until reset lifts.
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_write  = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
      bus.busy        = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.ex_branch_taken) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
          end else if (bus.ex_mul_start) begin
            bus.pc_write     = 1'b0;
            bus.ifid_write   = 1'b0;
            bus.idex_write   = 1'b0;
            bus.exmem_bubble = 1'b1;
          end else if (w_lu) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_bubble = 1'b1;
          end
        end
        MUL_WAIT: begin
          bus.pc_write     = 1'b0;
          bus.ifid_write   = 1'b0;
          bus.idex_write   = 1'b0;
          bus.exmem_bubble = 1'b1;
        end
        MUL_DONE: begin
          bus.mul_done = 1'b1;
          if (bus.ex_branch_taken) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
          end else if (w_lu) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.state = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (!bus.ex_branch_taken && bus.ex_mul_start) begin
            r_state <= MUL_WAIT;
            r_cnt   <= CNT_INIT;
          end
        end
        MUL_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= MUL_DONE;
        end
        MUL_DONE: r_state <= RUN;
        default:  r_state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= 16'd0;
      r_flush_count  <= 16'd0;
    end else begin
      if (!bus.pc_write && (r_stall_cycles != 16'hFFFF)) r_stall_cycles <= r_stall_cycles + 16'd1;
      if (bus.ifid_flush && (r_flush_count != 16'hFFFF)) r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: the driver pushes expected control vectors, a negedge monitor pops and compares.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if u_if ();

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  hazard_ctrl #(.MUL_LAT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef HAZARD_PERF_EN
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
`endif
    .bus          (u_if.slave)
  );

  // Vector: {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, mul_done, busy, state[1:0]}
  localparam logic [9:0] E_RST    = 10'b0010100000;
  localparam logic [9:0] E_RST_MW = 10'b0010100001;
  localparam logic [9:0] E_NORM   = 10'b1101000000;
  localparam logic [9:0] E_LU     = 10'b0001100000;
  localparam logic [9:0] E_BR     = 10'b1111100000;
  localparam logic [9:0] E_START  = 10'b0000010000;
  localparam logic [9:0] E_WAIT   = 10'b0000010101;
  localparam logic [9:0] E_DONE   = 10'b1101001110;
  localparam logic [9:0] E_DONE_LU = 10'b0001101110;

  logic [9:0] exp_q[$];
  int         id_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         vec_id = 0;

  logic [9:0] act;
  assign act = {u_if.pc_write, u_if.ifid_write, u_if.ifid_flush, u_if.idex_write,
                u_if.idex_bubble, u_if.exmem_bubble, u_if.mul_done, u_if.busy, u_if.state};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [9:0] e;
      int         id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL vec%0d: got %b required %b", id, act, e);
      end
    end
  end

  task automatic step(input logic rst, input logic br, input logic mul, input logic mr,
                      input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic chk, input logic [9:0] e);
    rst_n                = rst;
    u_if.ex_branch_taken = br;
    u_if.ex_mul_start    = mul;
    u_if.ex_mem_read     = mr;
    u_if.ex_rt           = ert;
    u_if.id_rs           = rs;
    u_if.id_rt           = rt;
    u_if.id_uses_rt      = urt;
    if (chk) begin
      exp_q.push_back(e);
      id_q.push_back(vec_id);
      vec_id++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic chk, input logic [9:0] e);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, chk, e);
  endtask

  task automatic check16(input string name, input logic [15:0] a, input logic [15:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, a, e);
    end
  endtask

  initial begin
    u_if.ex_branch_taken = 1'b0;
    u_if.ex_mul_start    = 1'b0;
    u_if.ex_mem_read     = 1'b0;
    u_if.ex_rt           = 5'd0;
    u_if.id_rs           = 5'd0;
    u_if.id_rt           = 5'd0;
    u_if.id_uses_rt      = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles; state only defined after the first reset edge.
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_RST);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_RST);
    idle(1'b1, E_NORM);

    // Load-use variants
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, E_LU);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, E_NORM);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b1, E_NORM);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b1, E_LU);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, E_NORM);

    // Branch beats multiply and load-use; state must stay RUN afterwards
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, E_BR);
    idle(1'b1, E_NORM);

    // Multiply with ex_mul_start held through the done cycle
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_START);
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_WAIT);
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, E_WAIT);
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_WAIT);
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_DONE);
    idle(1'b1, E_NORM);

    // Load-use resolved in the MUL_DONE cycle
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_START);
    idle(1'b1, E_WAIT);
    idle(1'b1, E_WAIT);
    idle(1'b1, E_WAIT);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, E_DONE_LU);
    idle(1'b1, E_NORM);

    // Reset in the second wait cycle aborts the multiply
    step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_START);
    idle(1'b1, E_WAIT);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_RST_MW);
    idle(1'b1, E_NORM);
    idle(1'b1, E_NORM);
    idle(1'b1, E_NORM);
    idle(1'b1, E_NORM);

`ifdef HAZARD_PERF_EN
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_RST);
    check16("stall_rst", stall_cycles, 16'd0);
    check16("flush_rst", flush_count, 16'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, E_LU);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b1, E_LU);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, E_LU);
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_BR);
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_BR);
    idle(1'b1, E_NORM);
    check16("stall_cnt", stall_cycles, 16'd3);
    check16("flush_cnt", flush_count, 16'd2);
    force dut.r_stall_cycles = 16'hFFFF;
    force dut.r_flush_count  = 16'hFFFF;
    idle(1'b0, E_NORM);
    release dut.r_stall_cycles;
    release dut.r_flush_count;
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, E_LU);
    check16("stall_sat", stall_cycles, 16'hFFFF);
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_BR);
    check16("flush_sat", flush_count, 16'hFFFF);
`endif

    // Bounded drain of the scoreboard before reporting
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage pipeline. It detects load-use hazards and taken-branch redirects, and sequences a multi-cycle multiply in EX. It drives the write-enable, bubble and flush controls of the PC, IF/ID and ID/EX pipeline registers. It sits beside the ID/EX register, observing the ID-stage source registers and the EX-stage control and destination fields.

## Interface
Parameters:
- MUL_LAT, default 4: total freeze cycles for a multiply, counted from its start cycle; legal range 2..15.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt as a source.
- ex_mem_read  in  1  MemRead of the instruction in EX, taken from the ID/EX register output.
- ex_rt  in  5  rt (load destination) of the instruction in EX.
- ex_branch_taken  in  1  the branch in EX resolved taken.
- ex_mul_start  in  1  the instruction in EX is a multi-cycle multiply.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clears to NOP on the next edge.
- idex_write  out  1  ID/EX load enable; 0 holds the register.
- idex_bubble  out  1  ID/EX loads zeroed control signals (RegWrite, MemToReg, MemRead, MemWrite = 0).
- exmem_bubble  out  1  EX/MEM loads zeroed control signals.
- mul_done  out  1  the multiply result is valid in EX this cycle.
- busy  out  1  state is not RUN.
- state  out  2  FSM state: RUN=0, MUL_WAIT=1, MUL_DONE=2.

## Operation
- FSM state and a 4-bit wait counter are registered. All other outputs decode combinationally from state and the current inputs.
- Defaults: pc_write=1, ifid_write=1, idex_write=1, all bubbles, flushes and mul_done=0.
- Load-use hazard, lu: ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- RUN state, priority branch > multiply > load-use:
  - ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1. Remain in RUN. ex_mul_start and lu are ignored.
  - ex_mul_start: freeze (pc_write=ifid_write=idex_write=0, exmem_bubble=1). Load cnt=MUL_LAT-1. Go to MUL_WAIT.
  - lu: pc_write=0, ifid_write=0, idex_bubble=1. Remain in RUN. A single bubble clears the hazard because the load advances to MEM.
- MUL_WAIT: freeze as above. cnt decrements each cycle. When cnt==1, go to MUL_DONE. All inputs are ignored.
- MUL_DONE: mul_done=1, no freeze, so the pipeline advances. ex_mul_start is ignored this cycle. The lu and branch rules apply as in RUN. Go to RUN.
- busy=1 in MUL_WAIT and MUL_DONE.

## Timing
- While rst_n=0: pc_write=ifid_write=idex_write=0, ifid_flush=1, idex_bubble=1, exmem_bubble=0, mul_done=0, busy=0.
- The reset clock edge sets state=RUN and cnt=0. Reset asserted during MUL_WAIT aborts the multiply. No mul_done is produced.
- Load-use and branch responses take effect in the same cycle as detection, with zero added latency.
- Multiply sequence: 1 start cycle (RUN) + MUL_LAT-1 MUL_WAIT cycles, all frozen, followed by 1 MUL_DONE cycle. Example with MUL_LAT=4: cycle0 start, cycles1-3 wait (cnt 3,2,1), cycle4 done.
- With MUL_LAT=2: exactly one MUL_WAIT cycle (cnt loaded 1).
- Back-to-back multiplies: the second multiply's ex_mul_start must be seen in RUN, at the earliest one cycle after MUL_DONE.

## Configuration
- HAZARD_PERF_EN defined: adds outputs stall_cycles[15:0] and flush_count[15:0]. Both are saturating at 16'hFFFF and cleared by reset.
  - stall_cycles increments on every cycle with pc_write=0 and rst_n=1.
  - flush_count increments on every cycle with ifid_flush=1 and rst_n=1.
- HAZARD_PERF_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, then release. Required: the reset-value outputs listed under Timing while low; state=0 and pc_write=1 after release with no hazards.
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5. Required: that cycle pc_write=0, ifid_write=0, idex_bubble=1. With ex_rt=0, no stall. With id_rt=5 and id_uses_rt=0, no stall.
- Branch priority: ex_branch_taken=1 together with ex_mul_start=1 and lu true. Required: ifid_flush=1, idex_bubble=1, pc_write=1, and state stays 0.
- Multiply, MUL_LAT=4: ex_mul_start pulse. Required: freeze for cycles 0-3, state=1 for cycles 1-3, mul_done=1 and state=2 at cycle 4, state=0 at cycle 5. ex_mul_start held high through cycle 4 does not restart the sequence.
- Reset mid-multiply: rst_n=0 at cycle 2 of the wait. Required: state=0 after the edge, mul_done is never asserted.
- With HAZARD_PERF_EN defined: 3 load-use stalls and 2 branch flushes. Required: stall_cycles=3, flush_count=2. Force the counters to 16'hFFFF, then stall once more. Required: stall_cycles stays at 16'hFFFF.
